// File: rtl/shiftreg16_in_if.sv
// rtl/shiftreg16_in_if.sv - serial receive and word handshake signals for shiftreg16_in
interface shiftreg16_in_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             sampling;
    logic             din;
    logic             rd;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             overrun;
    logic             abort;
    logic             busy;

    modport master (
        output en, sampling, din, rd,
        input  dout, valid, overrun, abort, busy
    );

    modport slave (
        input  en, sampling, din, rd,
        output dout, valid, overrun, abort, busy
    );
endinterface

// File: rtl/shiftreg16_in.sv
// rtl/shiftreg16_in.sv - SPI receive serial-to-parallel shift register with valid/read handshake
module shiftreg16_in #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    shiftreg16_in_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sr, sr_d, sr_shift;
    logic [CW-1:0]    cnt, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             abort_q, abort_d;
    logic             busy_q, busy_d;
    logic             accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_d;
            sr        <= sr_d;
            cnt       <= cnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            abort_q   <= abort_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state;
        sr_d      = sr;
        cnt_d     = cnt;
        dout_d    = dout_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        abort_d   = 1'b0;
        busy_d    = busy_q;
        accept    = bus.rd && valid_q;

        if (MSB_FIRST)
            sr_shift = {sr[WIDTH-2:0], bus.din};
        else
            sr_shift = {bus.din, sr[WIDTH-1:1]};

        if (accept) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state)
            IDLE: begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end
            SHIFT: begin
                // Dropping en mid-word throws the partial word away.
                if (!bus.en) begin
                    abort_d = (cnt != '0);
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    sr_d    = '0;
                end
            end
            default: begin
                cnt_d  = '0;
                busy_d = 1'b0;
            end
        endcase

        // en is evaluated before the strobe, so the first enabled cycle can already sample.
        if (bus.en) begin
            state_d = SHIFT;
            if (bus.sampling) begin
                sr_d = sr_shift;
                if (cnt == LAST) begin
                    dout_d    = sr_shift;
                    valid_d   = 1'b1;
                    overrun_d = accept ? 1'b0 : (valid_q ? 1'b1 : overrun_q);
                    cnt_d     = '0;
                    busy_d    = 1'b0;
                end else begin
                    cnt_d  = cnt + 1'b1;
                    busy_d = 1'b1;
                end
            end
        end else begin
            state_d = IDLE;
        end
    end

    assign bus.dout    = dout_q;
    assign bus.valid   = valid_q;
    assign bus.overrun = overrun_q;
    assign bus.abort   = abort_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_shiftreg16_in.sv
// tb/tb_shiftreg16_in.sv - directed self-checking bench for shiftreg16_in (MSB- and LSB-first instances)
module tb_shiftreg16_in;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic sampling = 1'b0;
    logic din = 1'b0;
    logic rd = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    shiftreg16_in_if #(.WIDTH(16)) if_a ();
    shiftreg16_in_if #(.WIDTH(16)) if_b ();

    assign if_a.en = en;
    assign if_a.sampling = sampling;
    assign if_a.din = din;
    assign if_a.rd = rd;
    assign if_b.en = en;
    assign if_b.sampling = sampling;
    assign if_b.din = din;
    assign if_b.rd = rd;

    shiftreg16_in #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    shiftreg16_in #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends bits [first, first+count) of word in transmit order, one strobe per 4 clk.
    task automatic send_bits(input logic [15:0] word, input bit msb, input int first,
                             input int count, input bit rd_last);
        for (int i = first; i < first + count; i++) begin
            din = msb ? word[15-i] : word[i];
            sampling = 1'b1;
            if (rd_last && i == first + count - 1) rd = 1'b1;
            tick();
            sampling = 1'b0;
            rd = 1'b0;
            repeat (3) tick();
        end
    endtask

    task automatic send_word(input logic [15:0] word, input bit msb);
        send_bits(word, msb, 0, 16, 1'b0);
    endtask

    task automatic read_pulse();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_dout", {16'h0, if_a.dout}, 32'h0);
        check("rst_valid", {31'h0, if_a.valid}, 32'h0);
        check("rst_overrun", {31'h0, if_a.overrun}, 32'h0);
        check("rst_abort", {31'h0, if_a.abort}, 32'h0);
        check("rst_busy", {31'h0, if_a.busy}, 32'h0);

        en = 1'b1;
        send_word(16'hAA33, 1'b1);
        check("w1_dout", {16'h0, if_a.dout}, 32'hAA33);
        check("w1_valid", {31'h0, if_a.valid}, 32'h1);
        check("w1_overrun", {31'h0, if_a.overrun}, 32'h0);
        check("w1_busy", {31'h0, if_a.busy}, 32'h0);
        check("w1_lsbdut_dout", {16'h0, if_b.dout}, 32'hCC55);
        read_pulse();
        check("w1_rd_valid", {31'h0, if_a.valid}, 32'h0);
        check("w1_rd_dout", {16'h0, if_a.dout}, 32'hAA33);

        send_word(16'h1234, 1'b1);
        check("b2b1_dout", {16'h0, if_a.dout}, 32'h1234);
        check("b2b1_valid", {31'h0, if_a.valid}, 32'h1);
        read_pulse();
        check("b2b1_rd_valid", {31'h0, if_a.valid}, 32'h0);
        send_word(16'hFEDC, 1'b1);
        check("b2b2_dout", {16'h0, if_a.dout}, 32'hFEDC);
        check("b2b2_valid", {31'h0, if_a.valid}, 32'h1);
        check("b2b2_overrun", {31'h0, if_a.overrun}, 32'h0);
        read_pulse();

        send_word(16'h00FF, 1'b1);
        send_word(16'h5A5A, 1'b1);
        check("ovr_dout", {16'h0, if_a.dout}, 32'h5A5A);
        check("ovr_valid", {31'h0, if_a.valid}, 32'h1);
        check("ovr_overrun", {31'h0, if_a.overrun}, 32'h1);
        read_pulse();
        check("ovr_rd_valid", {31'h0, if_a.valid}, 32'h0);
        check("ovr_rd_overrun", {31'h0, if_a.overrun}, 32'h0);

        send_word(16'h1111, 1'b1);
        send_word(16'h2222, 1'b1);
        check("sim_pre_overrun", {31'h0, if_a.overrun}, 32'h1);
        send_bits(16'h3333, 1'b1, 0, 16, 1'b1);
        check("sim_dout", {16'h0, if_a.dout}, 32'h3333);
        check("sim_valid", {31'h0, if_a.valid}, 32'h1);
        check("sim_overrun", {31'h0, if_a.overrun}, 32'h0);

        send_bits(16'hFFFF, 1'b1, 0, 7, 1'b0);
        check("abt_busy", {31'h0, if_a.busy}, 32'h1);
        en = 1'b0;
        tick();
        check("abt_pulse", {31'h0, if_a.abort}, 32'h1);
        check("abt_valid", {31'h0, if_a.valid}, 32'h1);
        check("abt_dout", {16'h0, if_a.dout}, 32'h3333);
        check("abt_busy_clr", {31'h0, if_a.busy}, 32'h0);
        sampling = 1'b1;
        din = 1'b1;
        tick();
        sampling = 1'b0;
        check("abt_pulse_end", {31'h0, if_a.abort}, 32'h0);
        check("abt_idle_busy", {31'h0, if_a.busy}, 32'h0);
        read_pulse();
        en = 1'b1;
        send_word(16'hC3C3, 1'b1);
        check("abt_next_dout", {16'h0, if_a.dout}, 32'hC3C3);
        check("abt_next_valid", {31'h0, if_a.valid}, 32'h1);
        read_pulse();

        send_bits(16'hFFFF, 1'b1, 0, 9, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_dout", {16'h0, if_a.dout}, 32'h0);
        check("mrst_valid", {31'h0, if_a.valid}, 32'h0);
        check("mrst_busy", {31'h0, if_a.busy}, 32'h0);
        check("mrst_abort", {31'h0, if_a.abort}, 32'h0);
        send_word(16'h8001, 1'b1);
        check("mrst_next_dout", {16'h0, if_a.dout}, 32'h8001);
        check("mrst_next_valid", {31'h0, if_a.valid}, 32'h1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_word(16'hAA33, 1'b0);
        check("lsb_dout", {16'h0, if_b.dout}, 32'hAA33);
        check("lsb_valid", {31'h0, if_b.valid}, 32'h1);
        check("lsb_msbdut_dout", {16'h0, if_a.dout}, 32'hCC55);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/shiftreg16_in.md
Name: shiftreg16_in

Overview:
Serial-to-parallel receive shift register for the SPI datapath. It is the receive-side counterpart of the 16-bit output shift register. It samples the serial input line on each `sampling` strobe from the rate generator and assembles WIDTH-bit words. Completed words are presented to the APB-side register logic through a valid/read handshake with overrun detection.

Parameters:
- WIDTH, 16, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0].

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  frame enable; same signal that enables the rate generator.
- sampling  in  1  one-clk strobe from the rate generator marking the serial sample point.
- din  in  1  serial data input (MISO).
- rd  in  1  one-clk read strobe from the register interface; consumes the held word.
- dout  out  WIDTH  last completed word (holding register).
- valid  out  1  dout holds an unread word.
- overrun  out  1  sticky; a word completed while the previous word was unread.
- abort  out  1  one-clk pulse: en dropped with a partial word in progress.
- busy  out  1  at least one bit of the current word has been received.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clk edge) clears: shift register, bit counter, dout=0, valid=0, overrun=0, abort=0, busy=0. Reset dominates every other input in the same cycle.
- State machine:
  - IDLE (en=0): counter held at 0; `sampling` and `din` are ignored.
  - IDLE -> SHIFT when en=1. No delay; a `sampling` strobe in the first en=1 cycle is accepted.
  - SHIFT: on each `sampling` strobe, din is shifted in and the counter increments.
    - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], din}.
    - MSB_FIRST=0: sr <= {din, sr[WIDTH-1:1]}.
    - busy = (counter != 0).
  - Word completion: the `sampling` strobe that arrives with counter = WIDTH-1.
    - On that same edge, dout <= the fully assembled word, including the current din bit.
    - valid <= 1; counter wraps to 0; busy <= 0.
    - The block stays in SHIFT, so back-to-back frames need no gap.
    - Latency: valid and dout change on the clk edge that registers the final strobe; they are visible the following cycle.
  - SHIFT -> IDLE when en=0.
    - If counter != 0: the partial word is discarded, abort pulses high for exactly one cycle, and dout, valid and overrun are unchanged.
    - If counter = 0: no abort pulse.
- Handshake:
  - Accept condition: rd=1 and valid=1. On accept, valid <= 0 and overrun <= 0.
  - rd with valid=0 has no effect.
  - dout is not cleared by a read.
- Overrun:
  - A word completes while valid=1 and no rd in that cycle: dout is overwritten with the new word, valid stays 1, overrun <= 1.
  - Completion and rd in the same cycle: the new word is loaded, valid stays 1, overrun is not set, and any existing overrun is cleared.
- en and sampling both changing in the same cycle: en is evaluated first. A strobe in a cycle with en=0 is ignored, even at the last bit.
- Reset mid-frame: the partial word is lost, with no abort pulse and no valid.
- The counter width is clog2(WIDTH). It never exceeds WIDTH-1.

Test Plan:
- Single word, MSB_FIRST=1, strobe every 4 clk, en held high, serial stream 0xAA33 sent MSB first -> after the 16th strobe, dout=0xAA33 and valid=1; overrun=0; busy=0. Then rd pulse -> valid=0, dout still 0xAA33.
- Back-to-back words 0x1234 then 0xFEDC, with rd after each -> two valid rises, dout=0x1234 then 0xFEDC; overrun never set.
- Overrun: two words 0x00FF then 0x5A5A with no rd -> dout=0x5A5A, valid=1, overrun=1. Then rd -> valid=0, overrun=0.
- Simultaneous: rd asserted in the exact cycle of the second word's final strobe -> dout=new word, valid=1, overrun=0.
- Abort: en dropped after 7 strobes -> one-cycle abort pulse, valid unchanged. Re-enable and send 0xC3C3 -> dout=0xC3C3, proving the counter restarted at 0.
- Reset mid-frame after 9 bits -> all outputs 0. The next full frame 0x8001 is received correctly. Repeat the single-word test with MSB_FIRST=0, sending 0xAA33 LSB first -> dout=0xAA33.
